// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and types for the VGA text-display blocks.
//   HCHAR/VCHAR    : character grid (columns x rows)
//   BITPERCH       : bits per character code
//   FONTHLEN/VLEN  : font glyph size in pixels
//   DIGITS         : character cells used per rendered value
//   BLANK_CODE     : character code rendered as an empty cell
//   sched_state_t  : state encoding of the frame scheduler
package vga_pkg;

  localparam int         HCHAR      = 50;
  localparam int         VCHAR      = 18;
  localparam int         BITPERCH   = 4;
  localparam int         FONTHLEN   = 8;
  localparam int         FONTVLEN   = 16;
  localparam int         DIGITS     = 3;
  localparam logic [3:0] BLANK_CODE = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_CONV = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } sched_state_t;

endpackage

// File: rtl/bcd_sat3.sv
// bcd_sat3: combinational binary-to-BCD converter, three digits, saturating.
//   bin  : N-bit unsigned input (N <= 10)
//   hund : hundreds digit
//   tens : tens digit
//   ones : ones digit
// Inputs of 1000 and above render as 9,9,9.
module bcd_sat3 #(
  parameter int N = 10
) (
  input  logic [N-1:0] bin,
  output logic [3:0]   hund,
  output logic [3:0]   tens,
  output logic [3:0]   ones
);

  logic [9:0] sat_s;

  // Clamp to 999, then split into decimal digits by constant division.
  always_comb begin
    if (10'(bin) >= 10'd1000) begin
      sat_s = 10'd999;
    end else begin
      sat_s = 10'(bin);
    end
    hund = 4'(sat_s / 10'd100);
    tens = 4'((sat_s / 10'd10) % 10'd10);
    ones = 4'(sat_s % 10'd10);
  end

endmodule

// File: rtl/bcd_frame_sched.sv
// bcd_frame_sched: per-frame scheduler filling the text back page with the
// decimal rendering of L binary values, then flipping pages on the next vsync.
//   clk, RSTn        : clock, asynchronous active-low reset
//   vsync            : display vertical sync (level)
//   bin_req/bin_idx  : request for value bin_idx
//   bin_data/bin_ack : value returned by the source, valid while bin_ack=1
//   wr_en/wr_page/wr_addr/wr_data : character write port into the back page
//   disp_page        : page the display currently reads
//   done             : one-cycle pulse when a pass completes
//   overrun          : sticky, vsync edge seen while a pass was running
// Build option: LEADING_ZERO_BLANK_EN renders leading zeros (all but the
// least significant digit) as BLANK_CODE.
module bcd_frame_sched
  import vga_pkg::*;
#(
  parameter int L = 3,
  parameter int N = 10
) (
  input  logic                             clk,
  input  logic                             RSTn,
  input  logic                             vsync,
  output logic                             bin_req,
  output logic [$clog2(L)-1:0]             bin_idx,
  input  logic [N-1:0]                     bin_data,
  input  logic                             bin_ack,
  output logic                             wr_en,
  output logic                             wr_page,
  output logic [$clog2(HCHAR*VCHAR)-1:0]   wr_addr,
  output logic [3:0]                       wr_data,
  output logic                             disp_page,
  output logic                             done,
  output logic                             overrun
);

  localparam int IW = $clog2(L);
  localparam int AW = $clog2(HCHAR*VCHAR);
  localparam logic [IW-1:0] IDX_LAST = IW'(L-1);

  sched_state_t    state_r, state_nx;
  logic [IW-1:0]   idx_r, idx_nx;
  logic [1:0]      d_r, d_nx;
  logic [N-1:0]    bin_val_r;
  logic [2:0][3:0] dig_r, conv_dig_s, dig_src_s;
  logic            pending_r, pending_nx;
  logic            vs_q_r;
  logic            edge_s, capture_s, disp_nx;
  logic [3:0]      hund_s, tens_s, ones_s;
  logic [AW-1:0]   wr_addr_nx;
  logic [3:0]      wr_data_nx;

  assign edge_s = vsync & ~vs_q_r;

  bcd_sat3 #(.N(N)) u_conv (
    .bin  (bin_val_r),
    .hund (hund_s),
    .tens (tens_s),
    .ones (ones_s)
  );

  // Digit order: index 0 is the most significant digit.
  always_comb begin
    conv_dig_s[2] = ones_s;
`ifdef LEADING_ZERO_BLANK_EN
    if (hund_s == 4'd0) begin
      conv_dig_s[0] = BLANK_CODE;
      if (tens_s == 4'd0) begin
        conv_dig_s[1] = BLANK_CODE;
      end else begin
        conv_dig_s[1] = tens_s;
      end
    end else begin
      conv_dig_s[0] = hund_s;
      conv_dig_s[1] = tens_s;
    end
`else
    conv_dig_s[0] = hund_s;
    conv_dig_s[1] = tens_s;
`endif
  end

  // Next-state and datapath control.
  always_comb begin
    state_nx   = state_r;
    idx_nx     = idx_r;
    d_nx       = d_r;
    pending_nx = pending_r;
    disp_nx    = disp_page;
    capture_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (edge_s) begin
          if (pending_r) begin
            disp_nx = ~disp_page;
          end else begin
            disp_nx = disp_page;
          end
          pending_nx = 1'b0;
          idx_nx     = '0;
          state_nx   = S_REQ;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_REQ: begin
        if (bin_ack) begin
          capture_s = 1'b1;
          state_nx  = S_CONV;
        end else begin
          state_nx = S_REQ;
        end
      end
      S_CONV: begin
        d_nx     = 2'd0;
        state_nx = S_WR;
      end
      S_WR: begin
        if (d_r == 2'd2) begin
          d_nx = 2'd0;
          if (idx_r == IDX_LAST) begin
            state_nx = S_DONE;
          end else begin
            idx_nx   = idx_r + IW'(1);
            state_nx = S_REQ;
          end
        end else begin
          d_nx = d_r + 2'd1;
        end
      end
      S_DONE: begin
        pending_nx = 1'b1;
        state_nx   = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from next-state values, so on the CONV->WR
  // transition the first digit comes straight from the converter.
  always_comb begin
    wr_addr_nx = wr_addr;
    wr_data_nx = wr_data;
    if (state_r == S_CONV) begin
      dig_src_s = conv_dig_s;
    end else begin
      dig_src_s = dig_r;
    end
    if (state_nx == S_WR) begin
      wr_addr_nx = AW'(idx_nx) * AW'(DIGITS) + AW'(d_nx);
      case (d_nx)
        2'd0:    wr_data_nx = dig_src_s[0];
        2'd1:    wr_data_nx = dig_src_s[1];
        2'd2:    wr_data_nx = dig_src_s[2];
        default: wr_data_nx = BLANK_CODE;
      endcase
    end else begin
      wr_addr_nx = wr_addr;
      wr_data_nx = wr_data;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state_r   <= S_IDLE;
      idx_r     <= '0;
      d_r       <= 2'd0;
      bin_val_r <= '0;
      dig_r     <= '0;
      pending_r <= 1'b0;
      vs_q_r    <= 1'b1;
      bin_req   <= 1'b0;
      bin_idx   <= '0;
      wr_en     <= 1'b0;
      wr_page   <= 1'b1;
      wr_addr   <= '0;
      wr_data   <= 4'h0;
      disp_page <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_r   <= state_nx;
      idx_r     <= idx_nx;
      d_r       <= d_nx;
      pending_r <= pending_nx;
      vs_q_r    <= vsync;
      if (capture_s) begin
        bin_val_r <= bin_data;
      end
      if (state_r == S_CONV) begin
        dig_r <= conv_dig_s;
      end
      bin_req   <= (state_nx == S_REQ);
      bin_idx   <= idx_nx;
      wr_en     <= (state_nx == S_WR);
      wr_addr   <= wr_addr_nx;
      wr_data   <= wr_data_nx;
      disp_page <= disp_nx;
      wr_page   <= ~disp_nx;
      done      <= (state_nx == S_DONE);
      overrun   <= overrun | (edge_s & (state_r != S_IDLE));
    end
  end

endmodule

// File: tb/tb_bcd_frame_sched.sv
`timescale 1ns/1ps
module tb_bcd_frame_sched;
  import vga_pkg::*;

  localparam int L  = 3;
  localparam int N  = 10;
  localparam int IW = $clog2(L);
  localparam int AW = $clog2(HCHAR*VCHAR);

  logic          clk = 1'b0;
  logic          RSTn, vsync, bin_req, bin_ack, wr_en, wr_page, disp_page, done, overrun;
  logic [IW-1:0] bin_idx;
  logic [N-1:0]  bin_data;
  logic [AW-1:0] wr_addr;
  logic [3:0]    wr_data;

  typedef struct { int page; int addr; int data; } wr_t;
  wr_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int vals[L];
  int delays[L];
  int src_idx;
  int model_disp, model_pending, model_overrun;
  bit done_seen;
  int done_cyc, done_cnt, first_wr_cyc, edge_cyc;

  bcd_frame_sched #(.L(L), .N(N)) dut (
    .clk(clk), .RSTn(RSTn), .vsync(vsync),
    .bin_req(bin_req), .bin_idx(bin_idx), .bin_data(bin_data), .bin_ack(bin_ack),
    .wr_en(wr_en), .wr_page(wr_page), .wr_addr(wr_addr), .wr_data(wr_data),
    .disp_page(disp_page), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Decimal digits of a value as the display should show them.
  function automatic int model_digit(input int v, input int k);
    int s;
    int dg[3];
    s = (v > 999) ? 999 : v;
    dg[0] = s / 100;
    dg[1] = (s / 10) % 10;
    dg[2] = s % 10;
`ifdef LEADING_ZERO_BLANK_EN
    if (dg[0] == 0) begin
      dg[0] = 15;
      if (dg[1] == 0) dg[1] = 15;
    end
`endif
    return dg[k];
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_bin_req"},   bin_req,   0);
    chk({tag, "_bin_idx"},   bin_idx,   0);
    chk({tag, "_wr_en"},     wr_en,     0);
    chk({tag, "_wr_page"},   wr_page,   1);
    chk({tag, "_wr_addr"},   wr_addr,   0);
    chk({tag, "_wr_data"},   wr_data,   0);
    chk({tag, "_disp_page"}, disp_page, 0);
    chk({tag, "_done"},      done,      0);
    chk({tag, "_overrun"},   overrun,   0);
  endtask

  // Value source: answers requests after delays[i] wait cycles and
  // queues the three writes the value must produce.
  initial begin : source
    int  wait_left;
    bit  armed;
    wr_t e;
    bin_ack  = 1'b0;
    bin_data = '0;
    armed    = 1'b0;
    wait_left = 0;
    forever begin
      @(negedge clk);
      bin_ack = 1'b0;
      if (!RSTn) begin
        armed = 1'b0;
      end else if (bin_req) begin
        chk("bin_idx", bin_idx, src_idx);
        if (!armed) begin
          armed = 1'b1;
          wait_left = delays[src_idx];
        end
        if (wait_left == 0) begin
          bin_ack  = 1'b1;
          bin_data = N'(vals[src_idx]);
          for (int k = 0; k < DIGITS; k++) begin
            e.page = 1 - model_disp;
            e.addr = src_idx * DIGITS + k;
            e.data = model_digit(vals[src_idx], k);
            exp_q.push_back(e);
          end
          src_idx++;
          armed = 1'b0;
        end else begin
          wait_left--;
        end
      end else begin
        armed = 1'b0;
      end
    end
  end

  // Monitor: compares every write against the scoreboard, records done.
  initial begin : monitor
    wr_t e;
    forever begin
      @(negedge clk);
      if (RSTn) begin
        if (wr_en) begin
          if (first_wr_cyc < 0) first_wr_cyc = cyc;
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_write: addr %0d data %0d with nothing expected", wr_addr, wr_data);
          end else begin
            e = exp_q.pop_front();
            chk("wr_page", wr_page, e.page);
            chk("wr_addr", wr_addr, e.addr);
            chk("wr_data", wr_data, e.data);
          end
        end
        if (done) begin
          done_seen = 1'b1;
          done_cyc  = cyc;
          done_cnt++;
        end
      end
    end
  end

  // mode 0: plain pass, 1: vsync edge during WR, 2: reset during WR
  task automatic run_pass(input int mode);
    int dsum;
    bit ok;
    int bad;
    dsum = 0;
    for (int i = 0; i < L; i++) dsum += delays[i];
    @(negedge clk);
    vsync = 1'b0;
    @(negedge clk);
    src_idx = 0; done_seen = 1'b0; done_cnt = 0; first_wr_cyc = -1;
    if (model_pending != 0) model_disp = 1 - model_disp;
    model_pending = 0;
    vsync = 1'b1;
    edge_cyc = cyc;
    @(negedge clk);
    chk("disp_page_after_edge", disp_page, model_disp);
    chk("wr_page_after_edge", wr_page, 1 - model_disp);
    chk("bin_req_cycle1", bin_req, 1);
    if (mode != 0) begin
      ok = 1'b0;
      for (int c = 0; c < 40 && !ok; c++) begin
        @(negedge clk);
        if (wr_en) ok = 1'b1;
      end
      chk("reach_wr", ok, 1);
    end
    if (mode == 1) begin
      vsync = 1'b0;
      @(negedge clk);
      vsync = 1'b1;
      model_overrun = 1;
      @(negedge clk);
      chk("overrun_set", overrun, 1);
    end
    if (mode == 2) begin
      #2 RSTn = 1'b0;
      #1 check_reset_outputs("async_rst");
      exp_q.delete();
      model_disp = 0; model_pending = 0; model_overrun = 0;
      repeat (2) @(negedge clk);
      RSTn = 1'b1;
      bad = 0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (bin_req || wr_en) bad++;
      end
      chk("idle_after_release_vsync_high", bad, 0);
      return;
    end
    ok = 1'b0;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk);
      if (done_seen) ok = 1'b1;
    end
    chk("done_seen", ok, 1);
    if (ok) chk("done_cycle", done_cyc - edge_cyc, 16 + dsum);
    chk("first_wr_cycle", first_wr_cyc - edge_cyc, 3 + delays[0]);
    model_pending = 1;
    repeat (2) @(negedge clk);
    chk("done_pulses", done_cnt, 1);
    chk("queue_empty", exp_q.size(), 0);
    chk("disp_page_end", disp_page, model_disp);
    chk("overrun", overrun, model_overrun);
  endtask

  initial begin : main
    RSTn = 1'b0; vsync = 1'b0;
    model_disp = 0; model_pending = 0; model_overrun = 0;
    src_idx = 0; done_seen = 1'b0; done_cnt = 0; first_wr_cyc = -1;
    for (int i = 0; i < L; i++) begin vals[i] = 0; delays[i] = 0; end
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    RSTn = 1'b1;
    repeat (2) @(negedge clk);

    vals = '{123, 45, 1000}; delays = '{0, 0, 0};
    run_pass(0);

    for (int i = 0; i < L; i++) vals[i] = $urandom_range(0, 1023);
    delays = '{0, 4, 0};
    run_pass(0);

    vals = '{0, 7, 40}; delays = '{0, 0, 0};
    run_pass(0);

    for (int i = 0; i < L; i++) vals[i] = $urandom_range(0, 1023);
    delays = '{0, 0, 0};
    run_pass(1);

    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < L; i++) begin
        vals[i]   = $urandom_range(0, 1023);
        delays[i] = $urandom_range(0, 3);
      end
      run_pass(0);
    end

    for (int i = 0; i < L; i++) vals[i] = $urandom_range(0, 1023);
    delays = '{0, 0, 0};
    run_pass(2);

    for (int i = 0; i < L; i++) vals[i] = $urandom_range(990, 1023);
    run_pass(0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bcd_frame_sched.md
# bcd_frame_sched

Frame-synchronous scheduler that fills the character buffer of the VGA text display with decimal renderings of binary values. On each rising edge of vsync it swaps the completed back page to the front. It then fetches L binary words over a request/acknowledge port, converts each word to three BCD digits through one shared converter, and writes the digits as 4-bit character codes into the new back page. It sits between the value source and the character buffer that feeds line selection and the font lookup.

## Interface
- L, 3: values per frame pass
- N, 10: bits per binary value (N ≤ 10)
- DIGITS, 3: character cells per value
- HCHAR, 50: characters per row
- VCHAR, 18: character rows
- BLANK_CODE, 4'hF: character code used for blanked cells
- clk  in  1  clock
- RSTn  in  1  reset, asynchronous, active-low
- vsync  in  1  display vertical sync, level
- bin_req  out  1  request for value bin_idx
- bin_idx  out  $clog2(L)  index of requested value
- bin_data  in  N  value; valid in the cycle where bin_ack=1
- bin_ack  in  1  source acknowledge
- wr_en  out  1  character write strobe
- wr_page  out  1  page being written (always ~disp_page)
- wr_addr  out  $clog2(HCHAR*VCHAR)  cell address in the page
- wr_data  out  4  character code
- disp_page  out  1  page the display reads
- done  out  1  one-cycle pulse at end of pass
- overrun  out  1  sticky; vsync edge arrived while a pass was running

## Operation
- vsync is registered into vs_q; edge = vsync & ~vs_q. vs_q resets to 1, so vsync high at reset release is not an edge.
- States: IDLE, REQ, CONV, WR, DONE.
- IDLE: on edge, toggle disp_page if pending=1 and clear pending. Set idx=0 and go to REQ.
- REQ: bin_req=1 and bin_idx=idx. bin_ack may arrive in the same cycle. On ack, capture bin_data and go to CONV.
- CONV: register the three digits from the converter and go to WR with d=0.
- WR: wr_en=1, wr_addr=idx*DIGITS+d, wr_data=digit[d] (d=0 is the most significant digit).
  - After d=2: if idx=L-1, go to DONE; otherwise increment idx and go to REQ.
- DONE: done=1, pending=1, go to IDLE.
- Conversion saturates: values ≥ 1000 produce digits 9,9,9.
- An edge outside IDLE sets overrun. It does not restart the pass and does not swap pages.
- Reset at any point forces IDLE and clears all state.
- Reset values:
  - outputs: bin_req=0, bin_idx=0, wr_en=0, wr_page=1, wr_addr=0, wr_data=0, disp_page=0, done=0, overrun=0
  - internal: pending=0, vs_q=1

## Timing
- Cycle 0: edge detected (swap registered here). REQ occupies cycle 1.
- With zero-wait ack, each value takes 5 cycles: REQ, CONV, WR×3.
- A full pass lasts 5L cycles from cycle 1, followed by DONE. For L=3: REQ at cycles 1, 6, 11; writes at 3–5, 8–10, 13–15; done at cycle 16.
- Every ack wait cycle adds one cycle. bin_req stays high and bin_idx stays stable until ack.
- wr_page is constant for the whole pass and changes only at a swap edge.

## Configuration
- LEADING_ZERO_BLANK_EN
  - Defined: leading zero digits except the least significant are written as BLANK_CODE. Examples: 7 → F,F,7; 40 → F,4,0; 0 → F,F,0.
  - Undefined: all digits are written as-is. Example: 7 → 0,0,7.

## Structure
- Shared package vga_pkg holds:
  - HCHAR, VCHAR, BITPERCH, FONTHLEN, FONTVLEN, DIGITS, BLANK_CODE
  - state enum typedef sched_state_t
- Sub-module bcd_sat3: combinational N-bit to 3×4-bit BCD conversion, saturating at 999. It is instantiated once and shared across all values.

## Test plan
- Reset release with vsync low, then vsync rises, L=3, values 123, 45, 1000, zero-wait ack → writes at addresses 0–8: 1,2,3,0,4,5,9,9,9 (blanking off). wr_page=1 throughout; done at cycle 16; disp_page stays 0.
- Second vsync edge after done → disp_page=1 on the cycle after the edge. The new pass writes with wr_page=0.
- Ack delayed 4 cycles on idx 1 → bin_req held high with bin_idx=1 for 4 cycles; done moves to cycle 20.
- vsync edge while in WR → overrun=1 (sticky). The pass completes normally and no swap occurs.
- RSTn asserted mid-WR → all outputs go to reset values asynchronously. With vsync high at release, no pass starts until vsync goes low then high.
- LEADING_ZERO_BLANK_EN defined, values 0, 7, 40 → data F,F,0 / F,F,7 / F,4,0.
